// File: rtl/mem_io_stage.sv
// rtl/mem_io_stage.sv - load/store stage to synchronous data RAM and LED/switch IO registers
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_io_stage #(
  parameter int          RAM_AW    = 12,
  parameter int          LED_W     = 16,
  parameter int          SW_W      = 16,
  parameter logic [5:0]  IO_REGION = 6'h3F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       ALUResult_i,
  input  logic [5:0]        Alu_resultHigh_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [3:0]        ram_we_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic [LED_W-1:0]  led_o,
  input  logic [SW_W-1:0]   switch_i
);

  localparam int AW = RAM_AW + 2;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state;

  // size encoding: 0 byte, 1 half, 2 word (undefined funct3 falls into word)
  logic [1:0]    req_size;
  logic          req_mis;
  logic          req_block;
  logic          req_io;
  logic [AW-1:0] req_lo;
  logic [3:0]    req_we;
  logic [31:0]   req_wdata;

  always_comb begin
    req_size = 2'd2;
    case (funct3_i[1:0])
      2'b00:   req_size = 2'd0;
      2'b01:   req_size = 2'd1;
      default: req_size = 2'd2;
    endcase
    req_mis = ((req_size == 2'd1) && ALUResult_i[0]) ||
              ((req_size == 2'd2) && (ALUResult_i[1:0] != 2'b00));
    req_io  = (Alu_resultHigh_i == IO_REGION);
    req_lo  = ALUResult_i[AW-1:0];
`ifndef MEM_MISALIGN_TRAP_EN
    if (req_size == 2'd1) req_lo[0]   = 1'b0;
    if (req_size == 2'd2) req_lo[1:0] = 2'b00;
`endif
    case (req_size)
      2'd0: begin
        req_we    = 4'b0001 << req_lo[1:0];
        req_wdata = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        req_we    = req_lo[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        req_we    = 4'b1111;
        req_wdata = wdata_i;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign req_block = req_mis;
`else
  assign req_block = 1'b0;
  wire unused_mis = req_mis;
`endif
  wire unused_hi = &{1'b0, ALUResult_i[31:AW]};

  logic [7:0]       off_q;
  logic [1:0]       size_q;
  logic             sign_q, io_q, rd_q, wr_q, block_q;
  logic [LED_W-1:0] led_d_q;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    return {{24{sgn & b[7]}}, b};
      2'd1:    return {{16{sgn & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      rdata_o     <= '0;
      ram_we_o    <= '0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      led_o       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      io_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      block_q     <= 1'b0;
      led_d_q     <= '0;
    end else begin
      done_o     <= 1'b0;
      misalign_o <= 1'b0;
      ram_we_o   <= '0;
      case (state)
        IDLE: if (req_valid_i) begin
          off_q       <= req_lo[7:0];
          size_q      <= req_size;
          sign_q      <= ~funct3_i[2];
          io_q        <= req_io;
          wr_q        <= MemWrite_i;
          rd_q        <= MemRead_i & ~MemWrite_i;
          block_q     <= req_block;
          led_d_q     <= wdata_i[LED_W-1:0];
          ram_addr_o  <= req_lo[AW-1:2];
          ram_wdata_o <= req_wdata;
          // RAM strobe is launched here so it is visible for exactly the ACCESS cycle
          if (!req_io && MemWrite_i && !req_block) ram_we_o <= req_we;
          busy_o <= 1'b1;
          state  <= ACCESS;
        end
        ACCESS: begin
          if (!io_q && rd_q) begin
            state <= WAIT;
          end else begin
            if (io_q && wr_q && !block_q && off_q == 8'h00) led_o <= led_d_q;
            rdata_o    <= (io_q && rd_q && !block_q && off_q == 8'h10) ? 32'(switch_i) : 32'h0;
            done_o     <= 1'b1;
            misalign_o <= block_q;
            state      <= RESP;
          end
        end
        WAIT: begin
          rdata_o    <= block_q ? 32'h0 : extract(ram_rdata_i, off_q[1:0], size_q, sign_q);
          done_o     <= 1'b1;
          misalign_o <= block_q;
          state      <= RESP;
        end
        RESP: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_stage.sv
// tb/tb_mem_io_stage.sv - directed vector bench for mem_io_stage with a behavioural RAM
module tb_mem_io_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] alu_result = '0;
  logic [5:0]  alu_high = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, misalign;
  logic [31:0] rdata;
  logic [11:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] led;
  logic [15:0] switches = '0;

  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] mem [0:4095];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_io_stage dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .MemRead_i(mem_read),
    .MemWrite_i(mem_write), .funct3_i(funct3), .ALUResult_i(alu_result),
    .Alu_resultHigh_i(alu_high), .wdata_i(wdata), .busy_o(busy), .done_o(done),
    .rdata_o(rdata), .misalign_o(misalign), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .led_o(led), .switch_i(switches)
  );

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_val;
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [5:0]  hi;
    logic [31:0] wd;
    logic [15:0] sw;
    logic        pre;
    logic [31:0] pre_val;
    int          lat;
    logic [3:0]  we;
    logic [31:0] ewd;
    logic [11:0] waddr;
    logic [31:0] erd;
    logic        mis;
    logic [15:0] led;
  } vec_t;

  function automatic vec_t mk(string nm, logic rd, logic wr, logic [2:0] f3, logic [31:0] a,
                              logic [5:0] hi, logic [31:0] wd, logic [15:0] sw, logic pre,
                              logic [31:0] pv, int lat, logic [3:0] we, logic [31:0] ewd,
                              logic [11:0] wa, logic [31:0] erd, logic mis, logic [15:0] ld);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.hi = hi; v.wd = wd;
    v.sw = sw; v.pre = pre; v.pre_val = pv; v.lat = lat; v.we = we; v.ewd = ewd;
    v.waddr = wa; v.erd = erd; v.mis = mis; v.led = ld;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, wecnt;
    logic [3:0]  wem;
    logic [31:0] wdv, rdv;
    logic [11:0] a1;
    logic        misv, got, busy1;
    lat = 0; wecnt = 0; wem = '0; wdv = '0; rdv = '0; a1 = '0; misv = 1'b0; got = 1'b0;
    busy1 = 1'b0;
    @(negedge clk);
    if (v.pre) begin
      pre_en = 1'b1; pre_addr = v.waddr; pre_val = v.pre_val;
      @(negedge clk);
      pre_en = 1'b0;
    end
    req_valid = 1'b1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    alu_result = v.addr; alu_high = v.hi; wdata = v.wd; switches = v.sw;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8 && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin a1 = ram_addr; busy1 = busy; end
      if (ram_we != 4'b0000) begin wecnt++; wem = ram_we; wdv = ram_wdata; end
      if (done) begin got = 1'b1; lat = k; misv = misalign; rdv = rdata; end
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " busy"}, {31'b0, busy1}, 32'd1);
    check({v.name, " we_mask"}, {28'b0, wem}, {28'b0, v.we});
    check({v.name, " we_cycles"}, 32'(wecnt), (v.we != 4'b0000) ? 32'd1 : 32'd0);
    if (v.we != 4'b0000) check({v.name, " ram_wdata"}, wdv, v.ewd);
    if (v.hi != 6'h3F) check({v.name, " ram_addr"}, {20'b0, a1}, {20'b0, v.waddr});
    if (v.rd && !v.wr) check({v.name, " rdata"}, rdv, v.erd);
    check({v.name, " misalign"}, {31'b0, misv}, {31'b0, v.mis});
    check({v.name, " led"}, {16'b0, led}, {16'b0, v.led});
    @(negedge clk);
    check({v.name, " busy_after"}, {31'b0, busy}, 32'd0);
    if (v.rd && !v.wr) check({v.name, " rdata_held"}, rdata, v.erd);
  endtask

  vec_t vt [22];
  int   dones;

  initial begin
    vt[0]  = mk("sw_10",   0,1,3'b010,32'h10,  6'h00,32'hDEADBEEF,16'h0,0,0, 2,4'hF,32'hDEADBEEF,12'd4,0,0,16'h0);
    vt[1]  = mk("lw_10",   1,0,3'b010,32'h10,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd4,32'hDEADBEEF,0,16'h0);
    vt[2]  = mk("sb_13",   0,1,3'b000,32'h13,  6'h00,32'hA5,16'h0,0,0, 2,4'h8,32'hA5A5A5A5,12'd4,0,0,16'h0);
    vt[3]  = mk("lb_13",   1,0,3'b000,32'h13,  6'h00,0,16'h0,1,32'hA5000000, 3,4'h0,0,12'd4,32'hFFFFFFA5,0,16'h0);
    vt[4]  = mk("lbu_13",  1,0,3'b100,32'h13,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd4,32'h000000A5,0,16'h0);
    vt[5]  = mk("lw_f3_3", 1,0,3'b011,32'h10,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd4,32'hA5000000,0,16'h0);
    vt[6]  = mk("lw_12",   1,0,3'b010,32'h12,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd4,
                TRAP ? 32'h0 : 32'hA5000000, TRAP,16'h0);
    vt[7]  = mk("io_sw",   0,1,3'b010,32'h3F00,6'h3F,32'h1234ABCD,16'h0,0,0, 2,4'h0,0,12'd0,0,0,16'hABCD);
    vt[8]  = mk("io_lw",   1,0,3'b010,32'h3F10,6'h3F,0,16'h8001,0,0, 2,4'h0,0,12'd0,32'h00008001,0,16'hABCD);
    vt[9]  = mk("io_rd04", 1,0,3'b010,32'h3F04,6'h3F,0,16'h8001,0,0, 2,4'h0,0,12'd0,32'h0,0,16'hABCD);
    vt[10] = mk("lh_21",   1,0,3'b001,32'h21,  6'h00,0,16'h0,1,32'h80007FFF, 3,4'h0,0,12'd8,
                TRAP ? 32'h0 : 32'h00007FFF, TRAP,16'hABCD);
    vt[11] = mk("sh_22",   0,1,3'b001,32'h22,  6'h00,32'h0000BEEF,16'h0,0,0, 2,4'hC,32'hBEEFBEEF,12'd8,0,0,16'hABCD);
    vt[12] = mk("lh_22",   1,0,3'b001,32'h22,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd8,32'hFFFFBEEF,0,16'hABCD);
    vt[13] = mk("lhu_22",  1,0,3'b101,32'h22,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd8,32'h0000BEEF,0,16'hABCD);
    vt[14] = mk("lb_20",   1,0,3'b000,32'h20,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd8,32'hFFFFFFFF,0,16'hABCD);
    vt[15] = mk("lbu_21",  1,0,3'b100,32'h21,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd8,32'h0000007F,0,16'hABCD);
    vt[16] = mk("sh_25",   0,1,3'b001,32'h25,  6'h00,32'h00001111,16'h0,0,0, 2,
                TRAP ? 4'h0 : 4'h3, 32'h11111111,12'd9,0,TRAP,16'hABCD);
    vt[17] = mk("noop",    0,0,3'b010,32'h10,  6'h00,0,16'h0,0,0, 2,4'h0,0,12'd4,0,0,16'hABCD);
    vt[18] = mk("rw_prio", 1,1,3'b000,32'h10,  6'h00,32'h77,16'h0,0,0, 2,4'h1,32'h77777777,12'd4,0,0,16'hABCD);
    vt[19] = mk("lw_10b",  1,0,3'b010,32'h10,  6'h00,0,16'h0,0,0, 3,4'h0,0,12'd4,32'hA5000077,0,16'hABCD);
    vt[20] = mk("io_wr08", 0,1,3'b010,32'h3F08,6'h3F,32'h5555,16'h0,0,0, 2,4'h0,0,12'd0,0,0,16'hABCD);
    vt[21] = mk("io_sw02", 0,1,3'b010,32'h3F02,6'h3F,32'h9999,16'h0,0,0, 2,4'h0,0,12'd0,0,TRAP,
                TRAP ? 16'hABCD : 16'h9999);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset misalign", {31'b0, misalign}, 32'd0);
    check("reset rdata", rdata, 32'h0);
    check("reset ram_we", {28'b0, ram_we}, 32'h0);
    check("reset ram_addr", {20'b0, ram_addr}, 32'h0);
    check("reset ram_wdata", ram_wdata, 32'h0);
    check("reset led", {16'b0, led}, 32'h0);

    for (int i = 0; i < 22; i++) run_vec(vt[i]);

    // request held high through a busy transaction must yield a single completion
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h3F10; alu_high = 6'h3F; switches = 16'h1234;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (done) dones++;
    end
    check("busy_ignore dones", 32'(dones), 32'd1);
    check("busy_ignore rdata", rdata, 32'h00001234);

    // reset while the load sits in WAIT
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h10; alu_high = 6'h00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_wait busy", {31'b0, busy}, 32'd0);
    check("rst_wait done", {31'b0, done}, 32'd0);
    check("rst_wait led", {16'b0, led}, 32'h0);
    check("rst_wait ram_we", {28'b0, ram_we}, 32'h0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_wait no_done", 32'(dones), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_io_stage.md
Name: mem_io_stage

Overview:
- Memory/IO access stage directly downstream of the ALU.
- Consumes the ALU result as an effective address, plus ALU result bits [13:8] as a region select. Performs load/store to a synchronous data RAM or to memory-mapped LED/switch registers.
- Returns load data with the proper byte/halfword extension and a done pulse for the writeback/control logic.
- Multi-cycle, single outstanding request, with a busy/done handshake.

Parameters:
- RAM_AW, 12, RAM word-address width; RAM word index = addr[RAM_AW+1:2]
- LED_W, 16, LED register width
- SW_W, 16, switch input width
- IO_REGION, 6'h3F, value of Alu_resultHigh_i that selects the IO region

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- req_valid_i  input  1  request strobe, sampled only in IDLE
- MemRead_i  input  1  load request
- MemWrite_i  input  1  store request
- funct3_i  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ALUResult_i  input  32  effective address
- Alu_resultHigh_i  input  6  address bits [13:8], region select
- wdata_i  input  32  store data (unshifted)
- busy_o  output  1  high from accept until the cycle after done_o
- done_o  output  1  one-cycle completion pulse
- rdata_o  output  32  load result, valid and held from done_o until next accept
- misalign_o  output  1  one-cycle pulse coincident with done_o on a misaligned access
- ram_addr_o  output  RAM_AW  RAM word address
- ram_we_o  output  4  RAM byte write enables
- ram_wdata_o  output  32  lane-aligned store data
- ram_rdata_i  input  32  RAM read data, one-cycle latency from ram_addr_o
- led_o  output  LED_W  LED register
- switch_i  input  SW_W  switch inputs

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE
  - busy_o=0, done_o=0, misalign_o=0, rdata_o=0
  - ram_we_o=0, ram_addr_o=0, ram_wdata_o=0
  - led_o=0
- Reset mid-operation: abort. No RAM write is issued after the reset edge and LED state is lost.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - On req_valid_i=1, capture address, region, funct3, wdata and the read/write flags; go to ACCESS; busy_o=1.
  - MemWrite_i has priority when both MemRead_i and MemWrite_i are set.
  - With neither set, the request is accepted and completes with no side effects.
- ACCESS (1 cycle):
  - RAM region:
    - Drive ram_addr_o.
    - Store: ram_we_o=lane mask for exactly this cycle, then RESP.
    - Load: go to WAIT.
  - IO region (Alu_resultHigh_i==IO_REGION):
    - Offset addr[7:0]=0x00 store: led_o <= wdata_i[LED_W-1:0].
    - Offset 0x10 load: sample switch_i, zero-extended.
    - Other offsets: reads return 0, writes are dropped.
    - Then go to RESP.
- WAIT: register ram_rdata_i, extract and extend, then go to RESP.
- RESP: done_o=1 (and misalign_o if flagged), rdata_o updated, then IDLE. busy_o stays 1 during RESP and drops in IDLE.
- Latency from the accept edge to done_o:
  - RAM load: 3 cycles
  - Store and any IO access: 2 cycles
- req_valid_i is ignored while busy_o=1; the requester must hold it or re-issue.
- Lanes:
  - sb: ram_we_o = 4'b0001<<addr[1:0]; wdata byte replicated to all lanes.
  - sh: ram_we_o = 4'b0011<<(addr[1]*2); halfword replicated.
  - sw: ram_we_o = 4'b1111.
- Load extract:
  - lb/lbu: byte addr[1:0], sign- or zero-extended.
  - lh/lhu: half addr[1], sign- or zero-extended.
  - lw: full word.
- Undefined funct3 is treated as word.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN
- Defined:
  - A misaligned access performs no RAM write and no LED update; loads return 0.
  - misalign_o pulses with done_o.
  - Latency is unchanged.
- Undefined:
  - Low address bits are forced to alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds.
  - misalign_o is tied to 0.

Test Plan:
- Reset, then sw addr 0x00000010 wdata 0xDEADBEEF -> ram_we_o=4'b1111 for one cycle, ram_addr_o=4, done_o 2 cycles after accept; then lw same address with RAM model -> rdata_o=0xDEADBEEF, done_o 3 cycles after accept.
- sb addr 0x13 wdata 0x000000A5 -> ram_we_o=4'b1000, ram_wdata_o=0xA5A5A5A5; lb addr 0x13 with RAM word 0xA5000000 -> rdata_o=0xFFFFFFA5; lbu -> 0x000000A5.
- sw addr 0x3F00, Alu_resultHigh_i=0x3F, wdata 0x1234ABCD -> led_o=0xABCD, ram_we_o stays 0; lw addr 0x3F10 with switch_i=0x8001 -> rdata_o=0x00008001 after 2 cycles.
- lh addr 0x21 -> with MEM_MISALIGN_TRAP_EN: misalign_o=1 with done_o, rdata_o=0; without: RAM word 0x8000_7FFF read at word 8, rdata_o=0x00007FFF, misalign_o=0.
- Second req_valid_i asserted while busy_o=1 -> ignored, exactly one done_o; rst asserted during WAIT of a load -> next cycle busy_o=0, done_o never pulses, led_o=0.
